// File: rtl/sub_seq_pkg.sv
// Shared types and constants for the multi-byte subtraction sequencer.
package sub_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/sub8_ci.sv
// 8-bit subtract slice, a + ~b + cin, built as a ripple of full-adder cells.
module sub8_ci
    import sub_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W-1:0] b_inv;
    logic [BYTE_W:0]   carry;

    assign b_inv    = ~b;
    assign carry[0] = cin;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b_inv[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
    end

    assign cout = carry[BYTE_W];

endmodule

// File: rtl/sub_seq_ctrl.sv
// Sequences one 8-bit subtract slice over NBYTES cycles, LSB byte first,
// with the slice carry chained through a register between cycles.
//
//   state | meaning
//   IDLE  | waiting for start_i
//   RUN   | one byte per cycle, idx 0 .. NBYTES-1
//   DONE  | one-cycle result pulse; start_i here restarts immediately
module sub_seq_ctrl
    import sub_seq_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] diff_o,
    output logic         cout_o,
    output logic         zero_o
);

    localparam int IDX_W = $clog2(NBYTES);

    sub_state_e        state;
    sub_state_e        state_next;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [W-1:0]      work;
    logic [W-1:0]      work_full;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic              accept;
    logic              last;
    logic [BYTE_W-1:0] slice_sum;
    logic              slice_cout;

    assign last = (idx == IDX_W'(NBYTES - 1));

    sub8_ci u_slice (
        .a    (a_reg[BYTE_W*idx +: BYTE_W]),
        .b    (b_reg[BYTE_W*idx +: BYTE_W]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Work word with the current byte merged in, so the final byte can be
    // published in the same edge it is computed.
    always_comb begin
        work_full = work;
        work_full[BYTE_W*idx +: BYTE_W] = slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            work   <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            diff_o <= '0;
            cout_o <= 1'b0;
            zero_o <= 1'b0;
        end else if (accept) begin
            a_reg <= a_i;
            b_reg <= b_i;
            idx   <= '0;
            carry <= 1'b1;
        end else if (state == RUN) begin
            work  <= work_full;
            carry <= slice_cout;
            idx   <= idx + IDX_W'(1);
            if (last) begin
                diff_o <= work_full;
                cout_o <= slice_cout;
                zero_o <= (work_full == '0);
            end
        end
    end

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Self-checking bench: cycle-level behavioural model (plain wide subtraction)
// compared every cycle, plus directed cases with literal expectations.
module tb_sub_seq_ctrl;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] diff_o;
    logic         cout_o;
    logic         zero_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    sub_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .diff_o  (diff_o),
        .cout_o  (cout_o),
        .zero_o  (zero_o)
    );

    always #5 clk = ~clk;

    // Reference model: an op occupies NBYTES cycles, then one done cycle.
    logic         m_busy, m_done, m_cout, m_zero;
    logic [W-1:0] m_diff, m_a, m_b;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_cout = 1'b0; m_zero = 1'b0;
            m_diff = '0;   m_a = '0;      m_b = '0;      m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_diff = m_a - m_b;
                    m_cout = (m_a >= m_b);
                    m_zero = (m_diff == '0);
                end
            end else if (start_i) begin
                m_a = a_i;
                m_b = b_i;
                m_busy = 1'b1;
                m_left = NBYTES;
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model busy", W'(busy_o), W'(m_busy));
            check("model done", W'(done_o), W'(m_done));
            check("model diff", diff_o, m_diff);
            check("model cout", W'(cout_o), W'(m_cout));
            check("model zero", W'(zero_o), W'(m_zero));
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, " busy"}, W'(busy_o), '0);
        check({tag, " done"}, W'(done_o), '0);
        check({tag, " diff"}, diff_o, '0);
        check({tag, " cout"}, W'(cout_o), '0);
        check({tag, " zero"}, W'(zero_o), '0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic ec, input logic ez,
                          input string tag);
        int lat;
        int busy_n;
        @(negedge clk);
        a_i = a; b_i = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 0; busy_n = 0;
        while (!done_o && lat < 20) begin
            if (busy_o) busy_n++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, W'(lat), W'(NBYTES));
        check({tag, " busy cycles"}, W'(busy_n), W'(NBYTES));
        check({tag, " diff"}, diff_o, ed);
        check({tag, " cout"}, W'(cout_o), W'(ec));
        check({tag, " zero"}, W'(zero_o), W'(ez));
    endtask

    initial begin
        int lat;
        #1 rst_n = 1'b0;
        #2 check_zero_outputs("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        run_op(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, "5-3");
        run_op(32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1, 1'b0, "borrow chain");
        run_op(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, "underflow");
        run_op(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, "equal");

        // Start held high across DONE: second result exactly NBYTES+1 later.
        @(negedge clk);
        a_i = 32'h0000_0300; b_i = 32'h0000_0200; start_i = 1'b1;
        lat = 0;
        while (!done_o && lat < 20) begin @(negedge clk); lat++; end
        check("b2b first diff", diff_o, 32'h0000_0100);
        a_i = 32'h8000_0000; b_i = 32'h0000_0001;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 20) begin @(negedge clk); lat++; end
        check("b2b spacing", W'(lat), W'(NBYTES + 1));
        check("b2b second diff", diff_o, 32'h7FFF_FFFF);
        check("b2b second cout", W'(cout_o), W'(1'b1));

        // Start pulse during RUN must not disturb the operation in flight.
        @(negedge clk);
        a_i = 32'h0000_1000; b_i = 32'h0000_0001; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        a_i = 32'hFFFF_FFFF; b_i = 32'h0000_0000; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 2;
        while (!done_o && lat < 20) begin @(negedge clk); lat++; end
        check("ignored start latency", W'(lat), W'(NBYTES));
        check("ignored start diff", diff_o, 32'h0000_0FFF);
        @(negedge clk);
        check("ignored start not queued", W'(busy_o), '0);

        // Reset while idx = 2.
        @(negedge clk);
        a_i = 32'h0102_0304; b_i = 32'h0000_0001; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("mid-op reset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no done after abort", W'(done_o), '0);
        end
        run_op(32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b1, 1'b0, "after reset");

        // Randomized traffic, with occasional equal operands and resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start_i = ($urandom % 3) != 0;
            case ($urandom % 4)
                0: a_i = $urandom % 256;
                default: a_i = $urandom;
            endcase
            case ($urandom % 5)
                0: b_i = a_i;
                1: b_i = $urandom % 256;
                default: b_i = $urandom;
            endcase
            if ($urandom % 97 == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        repeat (NBYTES + 3) @(negedge clk);
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
